// File: rtl/bus_cs_ready_ctrl_pkg.sv
// Shared types and default region map for the 8088 bus address latch,
// chip-select decoder and wait-state generator.
package bus_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_NUM_CS = 4;
  localparam int DEF_WAIT_W = 3;

  // Region 0 sits in the least significant slice of each packed constant.
  localparam logic [DEF_NUM_CS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000};
  localparam logic [DEF_NUM_CS*DEF_ADDR_W-1:0] DEF_REGION_MASK =
    {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000};
  localparam logic [DEF_NUM_CS-1:0] DEF_REGION_IOM = 4'b1100;
  localparam logic [DEF_NUM_CS*DEF_WAIT_W-1:0] DEF_REGION_WAIT =
    {3'd3, 3'd1, 3'd2, 3'd0};

  // RD and WR are active-low; both low together is still one access.
  function automatic logic is_strobe(input logic rd_n, input logic wr_n);
    return ~rd_n | ~wr_n;
  endfunction

endpackage

// File: rtl/bus_cs_ready_ctrl_if.sv
// Processor-side bus bundle: the CPU (master) drives the latch/strobe lines,
// the controller (slave) returns the latched address, chip selects and READY.
interface bus_cs_ready_ctrl_if
  import bus_dec_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_CS = DEF_NUM_CS
);
  logic              ALE;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] BusAddr;
  logic [ADDR_W-1:0] Address;
  logic [NUM_CS-1:0] CS;
  logic              READY;
  logic              Miss;

  modport master (
    output ALE, IOM, RD, WR, BusAddr,
    input  Address, CS, READY, Miss
  );

  modport slave (
    input  ALE, IOM, RD, WR, BusAddr,
    output Address, CS, READY, Miss
  );
endinterface

// File: rtl/bus_cs_ready_ctrl_wait_timer.sv
// Wait-state down counter: loaded with a non-zero count, decremented on
// request, and flags the final wait cycle when it holds 1.
module wait_timer
  import bus_dec_pkg::*;
#(
  parameter int WAIT_W = DEF_WAIT_W
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_count,
  input  logic              i_dec,
  output logic              o_last
);

  logic [WAIT_W-1:0] r_count;

  // Only ever loaded with N>0, and the zero guard keeps it from wrapping.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_count;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == WAIT_W'(1));

endmodule

// File: rtl/bus_cs_ready_ctrl.sv
// Registered 8088 address latch with programmable region decode, one-hot
// chip selects, per-region wait-state READY stretching and a miss pulse.
module bus_cs_ready_ctrl
  import bus_dec_pkg::*;
#(
  parameter int                          ADDR_W      = DEF_ADDR_W,
  parameter int                          NUM_CS      = DEF_NUM_CS,
  parameter int                          WAIT_W      = DEF_WAIT_W,
  parameter logic [NUM_CS*ADDR_W-1:0]    REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_CS*ADDR_W-1:0]    REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_CS-1:0]           REGION_IOM  = DEF_REGION_IOM,
  parameter logic [NUM_CS*WAIT_W-1:0]    REGION_WAIT = DEF_REGION_WAIT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bus_cs_ready_ctrl_if.slave   bus
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_iom;
  logic              r_cap_pend;
  logic [NUM_CS-1:0] r_cs;
  bus_state_t        r_state;
  logic              r_ready;
  logic              r_miss;

  logic              w_strobe;
  logic [NUM_CS-1:0] w_region_hit;
  logic [NUM_CS-1:0] w_cs_dec;
  logic              w_hit;
  logic [WAIT_W-1:0] w_wait;
  logic              w_accept;
  logic              w_load;
  logic              w_dec;
  logic              w_last;

  assign w_strobe = is_strobe(bus.RD, bus.WR);

  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_region
      assign w_region_hit[gi] =
        (((r_addr ^ REGION_BASE[gi*ADDR_W +: ADDR_W]) & REGION_MASK[gi*ADDR_W +: ADDR_W]) == '0)
        && (r_iom == REGION_IOM[gi]);
    end
  endgenerate

  // Scan from the top so the lowest-index hit overwrites the others.
  always_comb begin
    w_cs_dec = '0;
    w_hit    = 1'b0;
    w_wait   = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (w_region_hit[i]) begin
        w_cs_dec    = '0;
        w_cs_dec[i] = 1'b1;
        w_hit       = 1'b1;
        w_wait      = REGION_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

  assign w_accept = (r_state == ADDR) && !bus.ALE && w_strobe;
  assign w_load   = w_accept && w_hit && (w_wait != '0);
  assign w_dec    = (r_state == WAIT) && !bus.ALE;

  wait_timer #(
    .WAIT_W (WAIT_W)
  ) u_wait_timer (
    .clk     (CLK),
    .srst    (RESET),
    .i_load  (w_load),
    .i_count (w_wait),
    .i_dec   (w_dec),
    .o_last  (w_last)
  );

  // CS follows a capture by one edge and then holds until the next ALE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr     <= '0;
      r_iom      <= 1'b0;
      r_cap_pend <= 1'b0;
      r_cs       <= '0;
    end else begin
      r_cap_pend <= bus.ALE;
      if (bus.ALE) begin
        r_addr <= bus.BusAddr;
        r_iom  <= bus.IOM;
      end
      if (r_cap_pend) begin
        r_cs <= w_cs_dec;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_miss  <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      if (bus.ALE) begin
        r_state <= ADDR;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_ready <= 1'b1;
          end
          ADDR: begin
            if (w_strobe) begin
              if (!w_hit) begin
                r_miss  <= 1'b1;
                r_state <= DONE;
              end else if (w_wait == '0) begin
                r_state <= DONE;
              end else begin
                r_state <= WAIT;
                r_ready <= 1'b0;
              end
            end
          end
          WAIT: begin
            if (w_last) begin
              r_state <= DONE;
              r_ready <= 1'b1;
            end
          end
          DONE: begin
            if (!w_strobe) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.Address = r_addr;
  assign bus.CS      = r_cs;
  assign bus.READY   = r_ready;
  assign bus.Miss    = r_miss;

endmodule
